// File: rtl/adc_sample_ctrl.sv
// Conversion sequencer for the 12-bit serial ADC: builds sclk/cs_n, schedules
// frames from start pulses or a periodic timer, and deserialises each 16-bit frame.
module adc_sample_ctrl #(
   parameter int CLK_DIV       = 8,
   parameter int SAMPLE_PERIOD = 5000,
   parameter int QUIET_HALVES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        cont,
   input  logic        start,
   input  logic        ovr_clr,
   input  logic        sdata,
   output logic        sclk_out,
   output logic        cs_n,
   output logic [11:0] data,
   output logic        data_valid,
   output logic        busy,
   output logic        overrun,
   output logic        frame_err
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int TMR_W = $clog2(SAMPLE_PERIOD);
   localparam int QCT_W = $clog2(QUIET_HALVES + 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SAMPLE_PERIOD - 1);
   localparam logic [QCT_W-1:0] QCT_MAX = QCT_W'(QUIET_HALVES - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, FINISH, QUIET} state_t;

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;
   logic [TMR_W-1:0]   timer;
   logic [4:0]         bit_cnt;
   logic [QCT_W-1:0]   q_cnt;
   logic [15:0]        shift_reg;
   logic               sd_p0, sd_p1;
   logic               tick, timer_wrap, trig;

   assign tick       = (state != IDLE) && (div_cnt == DIV_MAX);
   assign timer_wrap = cont && en && (timer == TMR_MAX);
   assign trig       = en && (cont ? timer_wrap : start);

   // Stage p0/p1: two-flop synchroniser for the asynchronous ADC data line
   always_ff @(posedge clk) begin
      sd_p0 <= sdata;
      sd_p1 <= sd_p0;
   end

   always_ff @(posedge clk) begin
      if (state == SHIFT && tick && sclk_out)
         shift_reg <= {shift_reg[14:0], sd_p1};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         timer   <= '0;
         overrun <= 1'b0;
      end else begin
         if (state == IDLE || div_cnt == DIV_MAX)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 1'b1;

         if (!cont || !en || timer == TMR_MAX)
            timer <= '0;
         else
            timer <= timer + 1'b1;

         // A fresh overrun outranks a simultaneous clear
         if (trig && busy)
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cs_n       <= 1'b1;
         sclk_out   <= 1'b1;
         data       <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         bit_cnt    <= '0;
         q_cnt      <= '0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (trig) begin
                  state   <= SETUP;
                  cs_n    <= 1'b0;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
               end
            end
            SETUP: begin
               if (tick)
                  state <= SHIFT;
            end
            SHIFT: begin
               if (tick) begin
                  sclk_out <= ~sclk_out;
                  if (sclk_out) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end else if (bit_cnt == 5'd16) begin
                     // Closing rising edge: the full frame is already in shift_reg
                     state      <= FINISH;
                     cs_n       <= 1'b1;
                     data       <= shift_reg[11:0];
                     data_valid <= 1'b1;
                     frame_err  <= |shift_reg[15:12];
                  end
               end
            end
            FINISH: begin
               state <= QUIET;
               q_cnt <= '0;
            end
            QUIET: begin
               if (tick) begin
                  if (q_cnt == QCT_MAX) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     q_cnt <= q_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl with a behavioural serial ADC model.
module tb_adc_sample_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0, cont = 1'b0, start = 1'b0, ovr_clr = 1'b0;
   logic        sdata, sdata_m = 1'b0, sdata_t = 1'b0, rst_phase = 1'b1;
   logic        sclk_out, cs_n, data_valid, busy, overrun, frame_err;
   logic [11:0] data;

   assign sdata = rst_phase ? sdata_t : sdata_m;

   adc_sample_ctrl #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .QUIET_HALVES(2)) dut (
      .clk(clk), .rst(rst), .en(en), .cont(cont), .start(start), .ovr_clr(ovr_clr),
      .sdata(sdata), .sclk_out(sclk_out), .cs_n(cs_n), .data(data),
      .data_valid(data_valid), .busy(busy), .overrun(overrun), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;
   int cyc = 0;
   int vld_cnt = 0, stray_ferr = 0;
   int vld_t[$];
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_valid) begin
         vld_cnt++;
         vld_t.push_back(cyc);
      end
      if (frame_err && !data_valid) stray_ferr++;
   end

   // ADC model: first bit on cs_n fall, next bit after each sclk falling edge
   logic [15:0] adc_word = 16'h0;
   int          bit_idx = 0;
   int          fall_cnt = 0;
   always @(negedge cs_n or negedge sclk_out) begin
      if (sclk_out) begin
         sdata_m  = adc_word[15];
         bit_idx  = 14;
         fall_cnt = 0;
      end else if (!cs_n) begin
         fall_cnt++;
         if (bit_idx >= 0) begin
            sdata_m = adc_word[bit_idx];
            bit_idx--;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(negedge clk);
         if (data_valid) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
   endtask

   initial begin
      bit ok;
      int t0, lat, base, bad;

      // Reset held with sdata toggling
      repeat (10) begin
         @(negedge clk);
         sdata_t = ~sdata_t;
      end
      check("rst_cs_n", cs_n, 1);
      check("rst_sclk", sclk_out, 1);
      check("rst_data", data, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", data_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_ferr", frame_err, 0);
      rst = 1'b1;
      rst_phase = 1'b0;
      cycles(20);
      check("idle_cs_n", cs_n, 1);
      check("idle_busy", busy, 0);
      check("idle_no_valid", vld_cnt, 0);

      // Single shot
      en = 1'b1;
      adc_word = 16'h0A5C;
      pulse_start();
      t0 = cyc;
      wait_valid(120, ok);
      check("single_valid_seen", ok, 1);
      lat = cyc - t0;
      check("single_latency", (lat >= 65 && lat <= 69) ? 67 : lat, 67);
      check("single_data", data, 12'hA5C);
      check("single_ferr", frame_err, 0);
      wait_idle(50, ok);
      check("single_idle", ok, 1);
      check("single_falls", fall_cnt, 16);
      check("single_count", vld_cnt, 1);

      // Frame error
      adc_word = 16'h4FFF;
      pulse_start();
      wait_valid(120, ok);
      check("ferr_valid_seen", ok, 1);
      check("ferr_data", data, 12'hFFF);
      check("ferr_flag", frame_err, 1);
      wait_idle(50, ok);

      // Continuous mode, with a start pulse that must be ignored while busy
      adc_word = 16'h0123;
      base = vld_cnt;
      vld_t.delete();
      cont = 1'b1;
      cycles(150);
      pulse_start();
      cycles(899);
      cont = 1'b0;
      cycles(150);
      check("cont_count", vld_cnt - base, 10);
      bad = 0;
      for (int i = 1; i < vld_t.size(); i++)
         if (vld_t[i] - vld_t[i-1] != 100) bad++;
      check("cont_spacing", bad, 0);
      check("cont_overrun", overrun, 0);
      check("cont_data", data, 12'h123);

      // Overrun
      base = vld_cnt;
      pulse_start();
      cycles(9);
      pulse_start();
      check("ovr_set", overrun, 1);
      wait_valid(120, ok);
      wait_idle(50, ok);
      cycles(100);
      check("ovr_one_frame", vld_cnt - base, 1);
      check("ovr_sticky", overrun, 1);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      check("ovr_clear", overrun, 0);
      pulse_start();
      cycles(10);
      start = 1'b1;
      ovr_clr = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ovr_clr = 1'b0;
      check("ovr_set_wins", overrun, 1);
      wait_valid(120, ok);
      wait_idle(50, ok);

      // en dropped mid-frame in continuous mode
      adc_word = 16'h0777;
      base = vld_cnt;
      cont = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (busy) ok = 1'b1;
      end
      check("en_frame_start", ok, 1);
      cycles(10);
      en = 1'b0;
      wait_valid(120, ok);
      check("en_frame_done", ok, 1);
      check("en_data", data, 12'h777);
      wait_idle(50, ok);
      cycles(400);
      check("en_no_more", vld_cnt - base, 1);
      check("en_busy", busy, 0);
      cont = 1'b0;
      en = 1'b1;

      // Reset after the 8th falling edge
      adc_word = 16'h0ABC;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (fall_cnt >= 8) ok = 1'b1;
      end
      check("abort_reach8", ok, 1);
      cycles(1);
      rst = 1'b0;
      #1;
      check("abort_cs_n", cs_n, 1);
      check("abort_sclk", sclk_out, 1);
      check("abort_busy", busy, 0);
      check("abort_data", data, 0);
      base = vld_cnt;
      cycles(3);
      rst = 1'b1;
      cycles(100);
      check("abort_no_valid", vld_cnt - base, 0);
      check("abort_data_hold", data, 0);
      check("abort_idle", cs_n, 1);

      check("ferr_only_with_valid", stray_ferr, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
